fx2_slavefifo_sched: RTL
========================

Name: fx2_slavefifo_sched

Overview:
Arbiter and sequencer for the FX2LP synchronous slave-FIFO bus. It shares the single 16-bit FD bus and strobe set between two requesters: an RX stream draining EP2 (host OUT) and a TX stream filling EP6 (host IN). It handles FIFOADR switching with a turnaround cycle, bounded bursts, round-robin fairness and short-packet commit via PKTEND. It sits between the FX2 pins and the FPGA-side loopback/application datapath.

Parameters:
DATA_W, 16, FD bus and stream width
PKT_WORDS, 256, words per full EP6 packet (512 B); FX2 auto-commits at this count
BURST_MAX, 16, max words per grant before re-arbitration
PKTEND_TIMEOUT, 1024, idle cycles with a partial EP6 packet before forced PKTEND

Ports:
fx2_IFCLK  in  1  48 MHz interface clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
flag_ep2_avail  in  1  FLAGA; 1 = EP2 holds data
flag_ep6_space  in  1  FLAGD; 1 = EP6 accepts data
fifoadr  out  2  FIFOADR[1:0]; 00 = EP2, 10 = EP6
sloe_n  out  1  SLOE, active-low
slrd_n  out  1  SLRD, active-low
slwr_n  out  1  SLWR, active-low
pktend_n  out  1  PKTEND, active-low
fd_in  in  DATA_W  FD bus input
fd_out  out  DATA_W  FD bus drive value
fd_oe  out  1  FD tri-state enable, 1 = drive
rx_data  out  DATA_W  registered word read from EP2
rx_valid  out  1  registered; rx_data valid this cycle
rx_ready  in  1  consumer has room for at least 2 words
tx_data  in  DATA_W  word to send to EP6
tx_valid  in  1  tx_data valid
tx_ready  out  1  word accepted this cycle when tx_valid is also high
tx_flush  in  1  pulse: commit the partial EP6 packet
state_dbg  out  3  current state encoding

Behaviour:
- Reset values: fifoadr=00; sloe_n, slrd_n, slwr_n and pktend_n all 1; fd_oe=0; fd_out=0; rx_valid=0; tx_ready=0; all counters 0; flush_pend=0; state IDLE. Reset mid-burst releases all strobes immediately.
- States: IDLE, RD_ADR, RD, WR_ADR, WR, PKTEND.
- Requests:
  - rd_req = flag_ep2_avail & rx_ready
  - wr_req = flag_ep6_space & tx_valid
  - end_req = (flush_pend | timeout) & pkt_cnt != 0
- IDLE arbitration:
  - end_req has top priority.
  - Otherwise round-robin: last_grant flips on each grant, and the requester that was not last granted wins a tie.
  - If fifoadr already matches the winner, go straight to RD, WR or PKTEND. Otherwise go through RD_ADR or WR_ADR.
- RD_ADR / WR_ADR: one cycle. fifoadr is registered to the new value; all strobes high; fd_oe=0. This provides flag settle and bus turnaround. Next state is RD or WR; PKTEND goes via WR_ADR.
- RD:
  - sloe_n=0 for the whole state.
  - slrd_n = ~rd_req (combinational).
  - On each edge where slrd_n=0: rx_data<=fd_in and rx_valid<=1; otherwise rx_valid<=0. Latency is 1 cycle.
  - The consumer must accept any word arriving the cycle after it held rx_ready=1.
  - Exit to IDLE when rd_req=0 or burst_cnt reaches BURST_MAX.
- WR:
  - fd_oe=1 and fd_out=tx_data.
  - slwr_n = ~wr_req; tx_ready = wr_req.
  - Each write increments pkt_cnt modulo PKT_WORDS; wrap to 0 means the FX2 auto-commit occurred.
  - Exit to IDLE when wr_req=0 or burst_cnt reaches BURST_MAX.
- PKTEND: pktend_n=0 for exactly one cycle with fifoadr=10 and slwr_n=1. Clears pkt_cnt, flush_pend and the timeout counter. Next state IDLE.
- flush_pend:
  - Set by a tx_flush pulse; cleared in PKTEND.
  - A flush with pkt_cnt=0 is discarded, so no zero-length packet is sent.
  - A flush coinciding with a write is latched and served after the burst.
- Timeout counter:
  - Counts cycles with pkt_cnt!=0 and slwr_n=1.
  - Cleared on every write and in PKTEND.
  - Saturates at PKTEND_TIMEOUT.
- burst_cnt clears on every entry to RD or WR.
- slrd_n and slwr_n are never both 0. fd_oe=1 only in WR.

Decomposition:
- Shared package fx2_pkg holds:
  - the state enum
  - the FIFOADR constants FX2_ADR_EP2=2'b00 and FX2_ADR_EP6=2'b10
  - default PKT_WORDS and BURST_MAX
- One sub-module, fx2_pktend_timer, holds pkt_cnt, the timeout counter and flush_pend. It outputs end_req.

Test Plan:
- Reset then rd_req only (EP2 holds 40 words, rx_ready=1): IDLE, then RD directly with fifoadr=00. Bursts of 16, 16, 8 words; rx_valid goes high 1 cycle after each SLRD, and data matches the host pattern in order.
- rd_req and wr_req both held: grants alternate RD, WR_ADR, WR, RD_ADR, RD. Each burst is at most 16 words, each direction change costs exactly one ADR cycle, and fd_oe=0 in ADR and RD.
- Write 300 words with flag_ep6_space=1: pkt_cnt wraps at 256 and ends at 44. After 1024 idle cycles, one PKTEND pulse occurs, then pkt_cnt=0.
- tx_flush with pkt_cnt=0: no PKTEND issued. tx_flush asserted during a write burst with pkt_cnt=5 after the last word: PKTEND follows the burst end with exactly one cycle low.
- Drop flag_ep6_space mid-burst at word 7: slwr_n rises the same cycle, then the FSM returns to IDLE with no word lost (tx_ready=0). Restoring the flag resumes at word 8.
- Assert rst during WR at word 3: slwr_n=1, fd_oe=0 and fifoadr=00 asynchronously. After release, the FSM is in IDLE with pkt_cnt=0.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared types and constants for the FX2LP slave-FIFO scheduler.
package fx2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ADR = 3'd1,
    ST_RD     = 3'd2,
    ST_WR_ADR = 3'd3,
    ST_WR     = 3'd4,
    ST_PKTEND = 3'd5
  } fx2_state_t;

  localparam logic [1:0] FX2_ADR_EP2 = 2'b00;
  localparam logic [1:0] FX2_ADR_EP6 = 2'b10;

  localparam int FX2_PKT_WORDS      = 256;
  localparam int FX2_BURST_MAX      = 16;
  localparam int FX2_PKTEND_TIMEOUT = 1024;

endpackage

// File: rtl/fx2_pktend_timer.sv
// Tracks the partial EP6 packet fill level and decides when a PKTEND
// commit is due (explicit flush request or idle timeout).
module fx2_pktend_timer
  import fx2_pkg::*;
#(
  parameter int PKT_WORDS      = FX2_PKT_WORDS,
  parameter int PKTEND_TIMEOUT = FX2_PKTEND_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_stb,
  input  logic end_stb,
  input  logic tx_flush,
  output logic end_req
);

  localparam int PW = $clog2(PKT_WORDS);
  localparam int TW = $clog2(PKTEND_TIMEOUT + 1);

  logic [PW-1:0] pkt_cnt_r;
  logic [PW-1:0] pkt_next_s;
  logic [TW-1:0] tmo_cnt_r;
  logic          flush_pend_r;
  logic          timeout_s;

  // fill level after this cycle; a wrap to zero is the FX2 auto-commit
  always_comb begin
    pkt_next_s = pkt_cnt_r;
    if (end_stb) begin
      pkt_next_s = {PW{1'b0}};
    end else if (wr_stb) begin
      if (pkt_cnt_r == PW'(PKT_WORDS - 1)) begin
        pkt_next_s = {PW{1'b0}};
      end else begin
        pkt_next_s = pkt_cnt_r + PW'(1);
      end
    end else begin
      pkt_next_s = pkt_cnt_r;
    end
  end

  // fill level, pending flush and idle timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_r    <= {PW{1'b0}};
      flush_pend_r <= 1'b0;
      tmo_cnt_r    <= {TW{1'b0}};
    end else begin
      pkt_cnt_r <= pkt_next_s;
      // a flush that would leave nothing to commit is dropped
      if (end_stb || pkt_next_s == {PW{1'b0}}) begin
        flush_pend_r <= 1'b0;
      end else if (tx_flush) begin
        flush_pend_r <= 1'b1;
      end
      if (end_stb || wr_stb || pkt_cnt_r == {PW{1'b0}}) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else if (tmo_cnt_r != TW'(PKTEND_TIMEOUT)) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
    end
  end

  assign timeout_s = (tmo_cnt_r == TW'(PKTEND_TIMEOUT));
  assign end_req   = (flush_pend_r | timeout_s) & (pkt_cnt_r != {PW{1'b0}});

endmodule

// File: rtl/fx2_slavefifo_sched.sv
// Arbiter/sequencer sharing the FX2LP slave-FIFO bus between an EP2 reader
// (RX stream) and an EP6 writer (TX stream) with PKTEND short-packet commit.
module fx2_slavefifo_sched
  import fx2_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int PKT_WORDS      = FX2_PKT_WORDS,
  parameter int BURST_MAX      = FX2_BURST_MAX,
  parameter int PKTEND_TIMEOUT = FX2_PKTEND_TIMEOUT
) (
  input  logic              fx2_IFCLK,
  input  logic              rst,
  input  logic              flag_ep2_avail,
  input  logic              flag_ep6_space,
  output logic [1:0]        fifoadr,
  output logic              sloe_n,
  output logic              slrd_n,
  output logic              slwr_n,
  output logic              pktend_n,
  input  logic [DATA_W-1:0] fd_in,
  output logic [DATA_W-1:0] fd_out,
  output logic              fd_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              tx_flush,
  output logic [2:0]        state_dbg
);

  localparam int BW = $clog2(BURST_MAX + 1);

  fx2_state_t        state_r;
  logic [1:0]        fifoadr_r;
  logic              last_wr_r;
  logic              adr_for_end_r;
  logic [BW-1:0]     burst_cnt_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;

  logic rd_req_s;
  logic wr_req_s;
  logic end_req_s;
  logic rd_stb_s;
  logic wr_stb_s;
  logic burst_last_s;

  assign rd_req_s     = flag_ep2_avail & rx_ready;
  assign wr_req_s     = flag_ep6_space & tx_valid;
  assign rd_stb_s     = (state_r == ST_RD) & rd_req_s;
  assign wr_stb_s     = (state_r == ST_WR) & wr_req_s;
  assign burst_last_s = (burst_cnt_r == BW'(BURST_MAX - 1));

  fx2_pktend_timer #(
    .PKT_WORDS      (PKT_WORDS),
    .PKTEND_TIMEOUT (PKTEND_TIMEOUT)
  ) u_timer (
    .clk      (fx2_IFCLK),
    .rst      (rst),
    .wr_stb   (wr_stb_s),
    .end_stb  (state_r == ST_PKTEND),
    .tx_flush (tx_flush),
    .end_req  (end_req_s)
  );

  // arbitration, sequencing and the registered address / RX capture
  always_ff @(posedge fx2_IFCLK or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      fifoadr_r     <= FX2_ADR_EP2;
      last_wr_r     <= 1'b1;
      adr_for_end_r <= 1'b0;
      burst_cnt_r   <= {BW{1'b0}};
      rx_data_r     <= {DATA_W{1'b0}};
      rx_valid_r    <= 1'b0;
    end else begin
      rx_valid_r <= rd_stb_s;
      if (rd_stb_s) begin
        rx_data_r <= fd_in;
      end
      case (state_r)
        ST_IDLE: begin
          if (end_req_s) begin
            adr_for_end_r <= 1'b1;
            if (fifoadr_r == FX2_ADR_EP6) begin
              state_r <= ST_PKTEND;
            end else begin
              fifoadr_r <= FX2_ADR_EP6;
              state_r   <= ST_WR_ADR;
            end
          end else if (rd_req_s && (!wr_req_s || last_wr_r)) begin
            last_wr_r   <= 1'b0;
            burst_cnt_r <= {BW{1'b0}};
            if (fifoadr_r == FX2_ADR_EP2) begin
              state_r <= ST_RD;
            end else begin
              fifoadr_r <= FX2_ADR_EP2;
              state_r   <= ST_RD_ADR;
            end
          end else if (wr_req_s) begin
            last_wr_r     <= 1'b1;
            adr_for_end_r <= 1'b0;
            burst_cnt_r   <= {BW{1'b0}};
            if (fifoadr_r == FX2_ADR_EP6) begin
              state_r <= ST_WR;
            end else begin
              fifoadr_r <= FX2_ADR_EP6;
              state_r   <= ST_WR_ADR;
            end
          end
        end
        ST_RD_ADR: begin
          state_r <= ST_RD;
        end
        ST_WR_ADR: begin
          state_r <= adr_for_end_r ? ST_PKTEND : ST_WR;
        end
        ST_RD: begin
          if (rd_req_s) begin
            burst_cnt_r <= burst_cnt_r + BW'(1);
          end
          if (!rd_req_s || burst_last_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (wr_req_s) begin
            burst_cnt_r <= burst_cnt_r + BW'(1);
          end
          if (!wr_req_s || burst_last_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_PKTEND: begin
          adr_for_end_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // RD/WR strobes must react to flag drops in the same cycle, so they gate on live requests
  always_comb begin
    sloe_n   = 1'b1;
    slrd_n   = 1'b1;
    slwr_n   = 1'b1;
    pktend_n = 1'b1;
    fd_oe    = 1'b0;
    fd_out   = {DATA_W{1'b0}};
    tx_ready = 1'b0;
    case (state_r)
      ST_RD: begin
        sloe_n = 1'b0;
        slrd_n = ~rd_req_s;
      end
      ST_WR: begin
        fd_oe    = 1'b1;
        fd_out   = tx_data;
        slwr_n   = ~wr_req_s;
        tx_ready = wr_req_s;
      end
      ST_PKTEND: begin
        pktend_n = 1'b0;
      end
      default: begin
        sloe_n = 1'b1;
      end
    endcase
  end

  assign fifoadr   = fifoadr_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign state_dbg = state_r;

endmodule
